// File: rtl/cpu_types_pkg.sv
// Shared types for the 5-stage MIPS core: register indices, opcodes,
// hazard-controller state encoding and the pipeline-control bundle.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    localparam logic [5:0] HALT = 6'b111111;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hazstate_t;

    // One bit per latch/PC control line driven by the hazard controller.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_en;
    } pipe_ctl_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard terms: data-memory miss, load-use dependency and
// instruction-memory miss. Kept separate so a forwarding unit can reuse it.
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic     ihit,
    input  logic     dhit,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    input  logic     id_uses_rt,
    input  logic     ex_dREN,
    input  regbits_t ex_wsel,
    input  logic     mem_dREN,
    input  logic     mem_dWEN,
    output logic     dmiss,
    output logic     lduse,
    output logic     imiss
);

    assign dmiss = (mem_dREN | mem_dWEN) & ~dhit;

    // $zero is never a real dependency even when a load names it.
    assign lduse = ex_dREN & (ex_wsel != 5'd0) &
                   ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));

    assign imiss = ~ihit;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: priority-resolves hazards into latch enables/flushes,
// runs the halt-drain FSM (RUN -> DRAIN -> HALTED) and counts stall cycles.
module hazard_controller
    import cpu_types_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_halt,
    input  logic             ex_dREN,
    input  logic [4:0]       ex_wsel,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             ex_branch_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       dbg_state
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    hazstate_t   state, next_state;
    logic [DW-1:0] drain_cnt, next_drain;
    pipe_ctl_t   ctl;
    logic        dmiss, lduse, imiss;
    logic        stall_inc;

    hazard_detect u_detect (
        .ihit       (ihit),
        .dhit       (dhit),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .ex_dREN    (ex_dREN),
        .ex_wsel    (ex_wsel),
        .mem_dREN   (mem_dREN),
        .mem_dWEN   (mem_dWEN),
        .dmiss      (dmiss),
        .lduse      (lduse),
        .imiss      (imiss)
    );

    always_comb begin
        ctl        = '0;
        next_state = state;
        next_drain = drain_cnt;
        unique case (state)
            RUN: begin
                if (dmiss) begin
                    ctl = '0;
                end else if (ex_branch_taken) begin
                    ctl = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_en: 1'b1,
                            idex_flush: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1};
                end else if (lduse) begin
                    ctl = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b1,
                            idex_flush: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1};
                end else begin
                    if (imiss) begin
                        ctl = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_en: 1'b1,
                                idex_flush: 1'b0, exmem_en: 1'b1, memwb_en: 1'b1};
                    end else begin
                        ctl = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1,
                                idex_flush: 1'b0, exmem_en: 1'b1, memwb_en: 1'b1};
                    end
                    // Halt moves into ID/EX this cycle; IF/ID is flushed while draining.
                    if (id_halt) begin
                        next_state = DRAIN;
                        next_drain = DW'(DRAIN_CYCLES);
                    end
                end
            end
            DRAIN: begin
                ctl.ifid_flush = 1'b1;
                if (!dmiss) begin
                    ctl.idex_en  = 1'b1;
                    ctl.exmem_en = 1'b1;
                    ctl.memwb_en = 1'b1;
                    next_drain   = drain_cnt - DW'(1);
                    if (drain_cnt == DW'(1)) begin
                        next_state = HALTED;
                    end
                end
            end
            HALTED: begin
                ctl = '0;
            end
            default: begin
                next_state = RUN;
            end
        endcase
        if (RST) begin
            ctl = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_en: 1'b0,
                    idex_flush: 1'b1, exmem_en: 1'b0, memwb_en: 1'b0};
        end
    end

    assign stall_inc = ~ctl.pc_en & (state != HALTED);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            drain_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= next_state;
            drain_cnt <= next_drain;
            if (stall_inc) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign pc_en      = ctl.pc_en;
    assign ifid_en    = ctl.ifid_en;
    assign ifid_flush = ctl.ifid_flush;
    assign idex_en    = ctl.idex_en;
    assign idex_flush = ctl.idex_flush;
    assign exmem_en   = ctl.exmem_en;
    assign memwb_en   = ctl.memwb_en;
    assign halt       = (state == HALTED) & ~RST;
    assign dbg_state  = state;

endmodule
